// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and types for the shift-and-add multiplier
package mult_pkg;

    // Default operand width; product and multiplicand are twice this.
    localparam int MULT_WIDTH = 32;

    // Bit positions inside the FSM control word {a_sel, b_sel, prod_sel, add_sel, done_flag}.
    localparam int CTRL_A_SEL    = 4;
    localparam int CTRL_B_SEL    = 3;
    localparam int CTRL_PROD_SEL = 2;
    localparam int CTRL_ADD_SEL  = 1;
    localparam int CTRL_DONE     = 0;
    localparam int CTRL_BITS     = 5;

    // Control FSM state encodings, shared so bench monitors can decode them.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/mult_shreg.sv
// rtl/mult_shreg.sv - load/shift register, one-bit logical shift in a fixed direction
module mult_shreg #(
    parameter int W          = 32,
    parameter bit SHIFT_LEFT = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_resetn,
    input  logic         i_shift,
    input  logic [W-1:0] i_load_data,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;
    logic [W-1:0] w_shifted;

    // Zero fills the vacated end; the bit shifted out is simply dropped.
    assign w_shifted = SHIFT_LEFT ? (r_q << 1) : (r_q >> 1);

    // Load when i_shift is low, otherwise shift by one position.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_q <= '0;
        end else if (i_shift) begin
            r_q <= w_shifted;
        end else begin
            r_q <= i_load_data;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mult_datapath.sv
// rtl/mult_datapath.sv - shift-and-add multiplier datapath (optional b_zero output via MULT_B_ZERO_EN)
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               a_sel,
    input  logic               b_sel,
    input  logic               prod_sel,
    input  logic               add_sel,
    input  logic               done_flag,
    output logic               b_lsb,
`ifdef MULT_B_ZERO_EN
    output logic               b_zero,
`endif
    output logic [2*WIDTH-1:0] result,
    output logic               result_valid
);

    localparam int PW = 2 * WIDTH;

    logic [CTRL_BITS-1:0] w_ctrl;
    logic [PW-1:0]        w_a;
    logic [WIDTH-1:0]     w_b;
    logic                 w_capture;
    logic                 w_idle;

    logic [PW-1:0]        r_acc;
    logic [PW-1:0]        r_result;
    logic                 r_result_valid;
    logic                 r_done_q;

    // Repack the loose control bits in the FSM's output order.
    assign w_ctrl = {a_sel, b_sel, prod_sel, add_sel, done_flag};

    mult_shreg #(.W(PW), .SHIFT_LEFT(1'b1)) u_a_reg (
        .i_clk       (Clock),
        .i_resetn    (Reset),
        .i_shift     (w_ctrl[CTRL_A_SEL]),
        .i_load_data ({{WIDTH{1'b0}}, a_in}),
        .o_q         (w_a)
    );

    mult_shreg #(.W(WIDTH), .SHIFT_LEFT(1'b0)) u_b_reg (
        .i_clk       (Clock),
        .i_resetn    (Reset),
        .i_shift     (w_ctrl[CTRL_B_SEL]),
        .i_load_data (b_in),
        .o_q         (w_b)
    );

    assign b_lsb = w_b[0];

`ifdef MULT_B_ZERO_EN
    assign b_zero = (w_b == '0);
`endif

    // Accumulator: clear, add the pre-shift multiplicand, or hold.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_acc <= '0;
        end else if (!w_ctrl[CTRL_PROD_SEL]) begin
            r_acc <= '0;
        end else if (w_ctrl[CTRL_ADD_SEL]) begin
            r_acc <= r_acc + w_a;
        end
    end

    // Capture on the rising edge of done_flag; FSM back in IDLE retires the result.
    assign w_capture = w_ctrl[CTRL_DONE] && !r_done_q;
    assign w_idle    = !w_ctrl[CTRL_A_SEL] && !w_ctrl[CTRL_B_SEL] && !w_ctrl[CTRL_DONE];

    // Result register and valid flag; capture takes priority over the idle clear.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_done_q       <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_done_q <= w_ctrl[CTRL_DONE];
            if (w_capture) begin
                r_result       <= r_acc;
                r_result_valid <= 1'b1;
            end else if (w_idle) begin
                r_result_valid <= 1'b0;
            end
        end
    end

    assign result       = r_result;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_mult_datapath.sv
// tb/tb_mult_datapath.sv - randomized self-checking bench for mult_datapath
module tb_mult_datapath;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic [W-1:0]  a_in, b_in;
    logic          a_sel, b_sel, prod_sel, add_sel, done_flag;
    logic          b_lsb;
    logic [2*W-1:0] result;
    logic          result_valid;
`ifdef MULT_B_ZERO_EN
    logic          b_zero;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mult_datapath #(.WIDTH(W)) dut (
        .Clock        (clk),
        .Reset        (rstn),
        .a_in         (a_in),
        .b_in         (b_in),
        .a_sel        (a_sel),
        .b_sel        (b_sel),
        .prod_sel     (prod_sel),
        .add_sel      (add_sel),
        .done_flag    (done_flag),
        .b_lsb        (b_lsb),
`ifdef MULT_B_ZERO_EN
        .b_zero       (b_zero),
`endif
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl(input logic as, input logic bs, input logic ps, input logic ad, input logic dn);
        a_sel = as; b_sel = bs; prod_sel = ps; add_sel = ad; done_flag = dn;
    endtask

    // Plays the control FSM: IDLE load, CALC iterations, DONE, ack back to IDLE.
    task automatic run_mult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int extra);
        logic [63:0] bb;
        logic [63:0] prod;
        int          adds;
        bb   = 64'(b);
        prod = 64'(a) * 64'(b);
        adds = 0;
        a_in = a;
        b_in = b;
        ctrl(0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < W + extra; i++) begin
            check({tag, "_b_lsb"}, 64'(b_lsb), (bb >> i) & 64'd1);
`ifdef MULT_B_ZERO_EN
            if (i == 0) check({tag, "_b_zero"}, 64'(b_zero), 64'(b == '0));
`endif
            if (b_lsb) adds++;
            ctrl(1, 1, 1, b_lsb, 0);
            step();
        end
        if (b == '0) check({tag, "_no_add"}, 64'(adds), 64'd0);
        ctrl(1, 1, 1, 0, 1);
        step();
        check({tag, "_result"}, result, prod);
        check({tag, "_valid"}, 64'(result_valid), 64'd1);
        ctrl(1, 1, 1, 0, 1);
        step();
        check({tag, "_hold"}, result, prod);
        ctrl(0, 0, 0, 0, 0);
        step();
        check({tag, "_valid_clr"}, 64'(result_valid), 64'd0);
        check({tag, "_keep"}, result, prod);
    endtask

    initial begin
        logic [W-1:0] x;
        rstn = 1'b0;
        a_in = '0; b_in = '0;
        ctrl(0, 0, 0, 0, 0);

        // Reset with random controls and operands.
        for (int i = 0; i < 2; i++) begin
            a_in = $urandom; b_in = $urandom;
            ctrl($urandom, $urandom, $urandom, $urandom, $urandom);
            step();
        end
        check("rst_result", result, 64'd0);
        check("rst_valid", 64'(result_valid), 64'd0);
        check("rst_b_lsb", 64'(b_lsb), 64'd0);

        rstn = 1'b1;
        b_in = 32'd5;
        ctrl(0, 0, 0, 0, 0);
        step();
        check("load_b_lsb", 64'(b_lsb), 64'd1);

        run_mult("m3x5", 32'd3, 32'd5, 0);
        run_mult("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        run_mult("bzero", 32'h1234, 32'd0, 1);

        // Reset in the middle of a multiplication, then restart.
        a_in = 32'd7; b_in = 32'd9;
        ctrl(0, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 10; i++) begin
            ctrl(1, 1, 1, b_lsb, 0);
            step();
        end
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check("mid_rst_result", result, 64'd0);
        check("mid_rst_valid", 64'(result_valid), 64'd0);
        check("mid_rst_b_lsb", 64'(b_lsb), 64'd0);
        run_mult("m7x9", 32'd7, 32'd9, 0);

        // Direct control: add uses pre-shift A, then clear despite add_sel.
        x = $urandom_range(1, 32'h7FFF_FFFF);
        a_in = x;
        ctrl(0, 0, 0, 0, 0);
        step();
        ctrl(1, 1, 1, 1, 0);
        step();
        ctrl(1, 1, 1, 1, 1);
        step();
        check("direct_add", result, 64'(x));
        ctrl(1, 1, 0, 1, 0);
        step();
        ctrl(1, 1, 1, 0, 1);
        step();
        check("direct_clear", result, 64'd0);

        // Forced capture together with an IDLE control word: capture wins.
        ctrl(0, 0, 0, 0, 0);
        step();
        check("simul_pre", 64'(result_valid), 64'd0);
        ctrl(0, 0, 0, 0, 1);
        step();
        check("simul_valid", 64'(result_valid), 64'd1);
        ctrl(0, 0, 0, 0, 0);
        step();

        // Random operands with a random number of surplus CALC iterations.
        for (int t = 0; t < 8; t++) begin
            run_mult($sformatf("rnd%0d", t), W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
